// File: rtl/rr_arbiter_8_if.sv
// -----------------------------------------------------------------------------
// rr_arbiter_8_if: request/grant bundle for the 8-way round-robin arbiter.
//   req       8  requester k wants (or keeps holding) the resource
//   gnt       8  registered one-hot grant, zero when idle
//   gnt_idx   3  binary index of the current owner, zero when idle
//   gnt_valid 1  any grant active (OR of gnt)
//   timeout   1  one-cycle pulse when the watchdog revokes a grant
// master: the requester side; slave: the arbiter.
// -----------------------------------------------------------------------------
interface rr_arbiter_8_if;
   logic [7:0] req;
   logic [7:0] gnt;
   logic [2:0] gnt_idx;
   logic       gnt_valid;
   logic       timeout;

   modport master (
      output req,
      input  gnt,
      input  gnt_idx,
      input  gnt_valid,
      input  timeout
   );

   modport slave (
      input  req,
      output gnt,
      output gnt_idx,
      output gnt_valid,
      output timeout
   );
endinterface

// File: rtl/rr_arbiter_8.sv
// -----------------------------------------------------------------------------
// rr_arbiter_8: round-robin arbiter sharing one resource among 8 requesters,
// with grant-hold (the owner keeps the grant while its req bit stays high) and
// an optional watchdog that force-releases an owner after MAX_HOLD cycles.
//   i_clk  system clock, rising edge
//   i_rst  asynchronous active-high reset
//   bus    rr_arbiter_8_if.slave (req in; gnt, gnt_idx, gnt_valid, timeout out)
// All outputs are registered; there is no combinational path from req.
// -----------------------------------------------------------------------------
module rr_arbiter_8 #(
   parameter int unsigned MAX_HOLD = 16  // 0 disables the watchdog, else 1..255
) (
   input  logic          i_clk,
   input  logic          i_rst,
   rr_arbiter_8_if.slave bus
);

   typedef enum logic [0:0] {StIdle, StGrant} state_e;

   localparam bit         WdEn     = (MAX_HOLD != 0);
   localparam logic [7:0] HoldLast = 8'(MAX_HOLD - 1);

   state_e     r_state, w_state_nxt;
   logic [7:0] r_gnt, w_gnt_nxt;
   logic [2:0] r_idx, w_idx_nxt;
   logic       r_timeout, w_timeout_nxt;
   logic [2:0] r_ptr, w_ptr_nxt;
   logic [7:0] r_cnt, w_cnt_nxt;

   logic [2:0] w_cand;
   logic [2:0] w_winner;
   logic       w_any;

   // First requester found scanning ptr, ptr+1, ... with 3-bit wrap.
   always_comb begin
      w_cand   = r_ptr;
      w_winner = r_ptr;
      w_any    = 1'b0;
      for (int i = 0; i < 8; i++) begin
         w_cand = r_ptr + 3'(i);
         if (!w_any && bus.req[w_cand]) begin
            w_winner = w_cand;
            w_any    = 1'b1;
         end
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_gnt_nxt     = r_gnt;
      w_idx_nxt     = r_idx;
      w_timeout_nxt = 1'b0;
      w_ptr_nxt     = r_ptr;
      w_cnt_nxt     = r_cnt;
      case (r_state)
         StIdle: begin
            if (w_any) begin
               w_state_nxt = StGrant;
               w_gnt_nxt   = 8'b1 << w_winner;
               w_idx_nxt   = w_winner;
               w_cnt_nxt   = 8'd0;
               w_ptr_nxt   = w_winner + 3'd1;  // owner drops to lowest priority
            end
         end
         StGrant: begin
            // Release is checked first so it beats a coincident watchdog expiry.
            if (!bus.req[r_idx]) begin
               w_state_nxt = StIdle;
               w_gnt_nxt   = 8'h00;
               w_idx_nxt   = 3'd0;
            end else if (WdEn && (r_cnt == HoldLast)) begin
               w_state_nxt   = StIdle;
               w_gnt_nxt     = 8'h00;
               w_idx_nxt     = 3'd0;
               w_timeout_nxt = 1'b1;
            end else if (r_cnt != 8'hFF) begin
               w_cnt_nxt = r_cnt + 8'd1;
            end
         end
         default: begin
            w_state_nxt = StIdle;
            w_gnt_nxt   = 8'h00;
            w_idx_nxt   = 3'd0;
         end
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state   <= StIdle;
         r_gnt     <= 8'h00;
         r_idx     <= 3'd0;
         r_timeout <= 1'b0;
         r_ptr     <= 3'd0;
         r_cnt     <= 8'd0;
      end else begin
         r_state   <= w_state_nxt;
         r_gnt     <= w_gnt_nxt;
         r_idx     <= w_idx_nxt;
         r_timeout <= w_timeout_nxt;
         r_ptr     <= w_ptr_nxt;
         r_cnt     <= w_cnt_nxt;
      end
   end

   assign bus.gnt       = r_gnt;
   assign bus.gnt_idx   = r_idx;
   assign bus.gnt_valid = (r_state == StGrant);
   assign bus.timeout   = r_timeout;

endmodule

// File: doc/rr_arbiter_8.md
Name: rr_arbiter_8

Overview:
- Round-robin arbiter sharing one resource between 8 requesters.
- The grant is a registered one-hot vector, with the same encoding as our 3-to-8 decoder output: index k maps to bit k.
- Supports a grant-hold (lock) mode with an optional watchdog that force-releases an owner holding the resource too long.
- Sits in front of any shared datapath slot whose select is driven by a 3-bit index or an 8-bit one-hot.

Parameters:
- MAX_HOLD, 16, maximum consecutive GRANT cycles per ownership. 0 disables the watchdog. Legal range 0..255.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  8  request vector; bit k high means requester k wants or holds the resource.
- gnt  output 8  one-hot grant, or all zero when idle.
- gnt_idx  output 3  binary index of the current owner; 0 when idle.
- gnt_valid  output 1  high while any grant is active; equals OR of gnt.
- timeout  output 1  one-cycle pulse when the watchdog revokes a grant.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, gnt=8'h00, gnt_idx=3'd0, gnt_valid=0, timeout=0.
  - Priority pointer ptr=3'd0; hold counter cnt=0.
  - Reset asserted mid-grant drops gnt immediately (asynchronously), not at the next edge.
- Pointer semantics: the search order is ptr, ptr+1, ..., ptr+7, mod 8 with wrap-around. The first requesting index wins.
- State IDLE:
  - If req != 0, on the next edge: state=GRANT, gnt_idx=winner, gnt=one-hot(winner), gnt_valid=1, cnt=0, ptr=winner+1 mod 8 (7 wraps to 0).
  - If req == 0, remain in IDLE with outputs zero.
- Latency: req rising while IDLE gives gnt on the first clock edge after it is sampled high (1-cycle registered latency).
- State GRANT (owner o = gnt_idx):
  - If req[o] == 0: next edge goes to IDLE; gnt=0, gnt_valid=0, gnt_idx=0. This gives exactly one idle turnaround cycle before the next grant.
  - Else if MAX_HOLD != 0 and cnt == MAX_HOLD-1: next edge goes to IDLE, gnt cleared, timeout=1 for that one cycle. The pointer is already past o, so o has lowest priority at the next arbitration.
  - Else: hold; cnt increments, saturating at 255; outputs unchanged.
- Requests from non-owners during GRANT are ignored; they do not change the pointer. Changes on req bits other than req[o] have no effect.
- Simultaneous release and watchdog expiry: release wins; timeout stays 0.
- Ownership length:
  - With MAX_HOLD=N>0, gnt is high for at most N consecutive cycles per ownership.
  - With MAX_HOLD=1, every ownership lasts exactly 1 cycle, followed by 1 idle cycle.
- Invariants:
  - gnt is always 0 or exactly one-hot.
  - gnt == (gnt_valid ? 1<<gnt_idx : 0).
  - timeout and gnt_valid are never both 1.
- No combinational path from req to any output; all outputs are registered.
- Fairness: with all 8 requesting continuously and each releasing after its grant, grants rotate 0,1,...,7,0,... with one idle cycle between each.

Test Plan:
1. Reset: hold rst=1 for 3 cycles with req=8'hFF -> gnt=00, gnt_idx=0, gnt_valid=0, timeout=0. Assert rst during an active grant -> gnt drops to 00 before the next edge.
2. Single request: req=8'h20 from IDLE -> next edge gnt=8'h20, gnt_idx=5, gnt_valid=1. Drop req -> next edge gnt=00. Then req=8'h01 -> gnt=8'h01, proving ptr=6 wrapped to find 0.
3. Round-robin rotation: req=8'hFF with each owner dropping its bit for 1 cycle after being granted. Grant order is 0,1,2,...,7,0, one idle cycle between grants. gnt_idx after 7 is 0 (wrap).
4. Priority after pointer: after owner 2 releases (ptr=3), req=8'h85 (bits 0,2,7) -> grant 7, then 0, then 2.
5. Watchdog: MAX_HOLD=4, req=8'h08 held high -> gnt=8'h08 for exactly 4 cycles, then gnt=00 with timeout=1 for 1 cycle, then gnt=8'h08 again. With req=8'h18 instead, the second grant goes to 4 (bit 4), not 3.
6. Corner cases:
   - Release on the same cycle cnt==MAX_HOLD-1 -> IDLE with timeout=0.
   - MAX_HOLD=0 with req held 300 cycles -> grant never revoked; cnt saturates without wrap side effects.
   - Non-owner bits toggling during GRANT leave gnt unchanged.
